avalon_arbiter: RTL and testbench

Shares the single Avalon-MM master port of the MIPS CPU between the instruction-fetch requester and the data load/store requester. It serialises requests, arbitrates by a fixed or round-robin policy, and steers byte lanes for sub-word stores and loads. It holds bus signals stable across `av_waitrequest` and optionally times out stalled transfers. It returns each result to its requester with a one-cycle acknowledge.

---
 rtl/avalon_pkg.sv | 39 +++
 rtl/byte_lane_steer.sv | 48 ++++
 rtl/avalon_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_avalon_arbiter.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_pkg
//  Description : Shared types and constants for the Avalon-MM arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package avalon_pkg;

   // Arbiter FSM encodings (kept as plain constants for legacy tooling)
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BUS_I = 2'd1;
   localparam logic [1:0] ST_BUS_D = 2'd2;
   localparam logic [1:0] ST_ACK   = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      BUS_I = ST_BUS_I,
      BUS_D = ST_BUS_D,
      ACK   = ST_ACK
   } arb_state_t;

   // Access size codes; 2'b11 is handled as a byte access
   localparam logic [1:0] SIZE_WORD = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_BYTE = 2'b10;

   localparam logic [3:0] BE_ALL = 4'b1111;

   // Identity of the requester that won the most recent grant
   localparam logic GRANT_INSTR = 1'b0;
   localparam logic GRANT_DATA  = 1'b1;

   // Clear the byte-offset bits so the bus only ever sees word addresses
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage : avalon_pkg
`default_nettype wire

// File: rtl/byte_lane_steer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_lane_steer
//  Description : Combinational byte-lane logic for sub-word loads/stores:
//                byteenable, store data shift, load data shift, misalign.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_lane_steer
   import avalon_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_offset,
   input  logic [31:0] i_wdata,
   input  logic [1:0]  i_rd_offset,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata,
   output logic        o_misalign
);

   // Lane enables and alignment check derived from size and byte offset
   always_comb begin
      o_be       = BE_ALL;
      o_misalign = 1'b0;
      case (i_size)
         SIZE_WORD: begin
            o_be       = BE_ALL;
            o_misalign = (i_offset != 2'b00);
         end
         SIZE_HALF: begin
            o_be       = i_offset[1] ? 4'b1100 : 4'b0011;
            o_misalign = i_offset[0];
         end
         default: begin
            // SIZE_BYTE and the reserved code both select a single lane
            o_be       = 4'b0001 << i_offset;
            o_misalign = 1'b0;
         end
      endcase
   end

   // Store payload moves up to its lane; load data comes down unmasked
   assign o_wdata = i_wdata << {i_offset, 3'b000};
   assign o_rdata = i_rdata >> {i_rd_offset, 3'b000};

endmodule : byte_lane_steer
`default_nettype wire

// File: rtl/avalon_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_arbiter
//  Description : Shares one Avalon-MM master between instruction fetch and
//                data load/store, with lane steering and optional timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module avalon_arbiter
   import avalon_pkg::*;
#(
   parameter int DATA_FIRST = 1,
   parameter int WAIT_LIMIT = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_req,
   input  logic [31:0] instr_address,
   output logic        instr_ack,
   output logic [31:0] instr_rdata,
   output logic        instr_err,
   input  logic        data_req,
   input  logic        data_we,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_address,
   input  logic [31:0] data_wdata,
   output logic        data_ack,
   output logic [31:0] data_rdata,
   output logic        data_err,
   output logic [31:0] av_address,
   output logic        av_read,
   output logic        av_write,
   output logic [31:0] av_writedata,
   output logic [3:0]  av_byteenable,
   input  logic        av_waitrequest,
   input  logic [31:0] av_readdata
);

   localparam int             CW      = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
   localparam logic [CW-1:0]  C_LIMIT = CW'(WAIT_LIMIT);

   arb_state_t    r_state;
   logic          r_last_grant;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_rd_off;
   logic          r_we;

   logic          r_instr_ack;
   logic [31:0]   r_instr_rdata;
   logic          r_instr_err;
   logic          r_data_ack;
   logic [31:0]   r_data_rdata;
   logic          r_data_err;
   logic [31:0]   r_av_address;
   logic          r_av_read;
   logic          r_av_write;
   logic [31:0]   r_av_writedata;
   logic [3:0]    r_av_byteenable;

   logic          w_grant_i;
   logic          w_grant_d;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata_sh;
   logic [31:0]   w_rdata_sh;
   logic          w_misalign;
   logic [CW-1:0] w_cnt_next;
   logic          w_timeout;

   // Lane steering works on the live request in IDLE and on the latched
   // offset when the load data comes back.
   byte_lane_steer u_steer (
      .i_size      (data_size),
      .i_offset    (data_address[1:0]),
      .i_wdata     (data_wdata),
      .i_rd_offset (r_rd_off),
      .i_rdata     (av_readdata),
      .o_be        (w_be),
      .o_wdata     (w_wdata_sh),
      .o_rdata     (w_rdata_sh),
      .o_misalign  (w_misalign)
   );

   // Choose a winner: fixed data priority, or whoever did not win last time
   always_comb begin
      w_grant_i = 1'b0;
      w_grant_d = 1'b0;
      if (data_req && instr_req) begin
         if ((DATA_FIRST != 0) || (r_last_grant == GRANT_INSTR)) begin
            w_grant_d = 1'b1;
         end else begin
            w_grant_i = 1'b1;
         end
      end else if (data_req) begin
         w_grant_d = 1'b1;
      end else if (instr_req) begin
         w_grant_i = 1'b1;
      end
   end

   // Stall counter reaching the limit aborts the transfer (limit 0 = never)
   assign w_cnt_next = r_cnt + CW'(1);
   assign w_timeout  = (WAIT_LIMIT != 0) && (w_cnt_next == C_LIMIT);

   // Arbiter FSM, request latches and all registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= IDLE;
         r_last_grant    <= GRANT_INSTR;
         r_cnt           <= '0;
         r_rd_off        <= 2'b00;
         r_we            <= 1'b0;
         r_instr_ack     <= 1'b0;
         r_instr_rdata   <= 32'h0;
         r_instr_err     <= 1'b0;
         r_data_ack      <= 1'b0;
         r_data_rdata    <= 32'h0;
         r_data_err      <= 1'b0;
         r_av_address    <= 32'h0;
         r_av_read       <= 1'b0;
         r_av_write      <= 1'b0;
         r_av_writedata  <= 32'h0;
         r_av_byteenable <= 4'b0000;
      end else begin
         // Acks and errors are single-cycle pulses
         r_instr_ack <= 1'b0;
         r_instr_err <= 1'b0;
         r_data_ack  <= 1'b0;
         r_data_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_grant_d) begin
                  r_last_grant <= GRANT_DATA;
                  r_cnt        <= '0;
                  r_rd_off     <= data_address[1:0];
                  r_we         <= data_we;
                  if (w_misalign) begin
                     // Rejected without touching the bus
                     r_state    <= ACK;
                     r_data_ack <= 1'b1;
                     r_data_err <= 1'b1;
                  end else begin
                     r_state         <= BUS_D;
                     r_av_address    <= word_align(data_address);
                     r_av_read       <= ~data_we;
                     r_av_write      <= data_we;
                     r_av_writedata  <= w_wdata_sh;
                     r_av_byteenable <= w_be;
                  end
               end else if (w_grant_i) begin
                  r_last_grant    <= GRANT_INSTR;
                  r_cnt           <= '0;
                  r_we            <= 1'b0;
                  r_state         <= BUS_I;
                  r_av_address    <= word_align(instr_address);
                  r_av_read       <= 1'b1;
                  r_av_write      <= 1'b0;
                  r_av_writedata  <= 32'h0;
                  r_av_byteenable <= BE_ALL;
               end
            end
            BUS_I, BUS_D: begin
               // Bus fields are left untouched while the slave stalls
               if (!av_waitrequest) begin
                  r_state         <= ACK;
                  r_av_read       <= 1'b0;
                  r_av_write      <= 1'b0;
                  r_av_byteenable <= 4'b0000;
                  if (r_state == BUS_D) begin
                     r_data_ack <= 1'b1;
                     if (!r_we) begin
                        r_data_rdata <= w_rdata_sh;
                     end
                  end else begin
                     r_instr_ack   <= 1'b1;
                     r_instr_rdata <= av_readdata;
                  end
               end else if (w_timeout) begin
                  r_state         <= ACK;
                  r_av_read       <= 1'b0;
                  r_av_write      <= 1'b0;
                  r_av_byteenable <= 4'b0000;
                  if (r_state == BUS_D) begin
                     r_data_ack <= 1'b1;
                     r_data_err <= 1'b1;
                  end else begin
                     r_instr_ack <= 1'b1;
                     r_instr_err <= 1'b1;
                  end
               end else begin
                  r_cnt <= w_cnt_next;
               end
            end
            ACK: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign instr_ack     = r_instr_ack;
   assign instr_rdata   = r_instr_rdata;
   assign instr_err     = r_instr_err;
   assign data_ack      = r_data_ack;
   assign data_rdata    = r_data_rdata;
   assign data_err      = r_data_err;
   assign av_address    = r_av_address;
   assign av_read       = r_av_read;
   assign av_write      = r_av_write;
   assign av_writedata  = r_av_writedata;
   assign av_byteenable = r_av_byteenable;

endmodule : avalon_arbiter
`default_nettype wire

// File: tb/tb_avalon_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_avalon_arbiter
//  Description : Self-checking bench; instance A uses data priority with a
//                stall limit of 5, instance B uses round-robin, no limit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_req;
   logic [31:0] instr_address;
   logic        data_req;
   logic        data_we;
   logic [1:0]  data_size;
   logic [31:0] data_address;
   logic [31:0] data_wdata;
   logic        av_waitrequest;
   logic [31:0] av_readdata;

   logic        a_instr_ack, a_instr_err, a_data_ack, a_data_err, a_av_read, a_av_write;
   logic [31:0] a_instr_rdata, a_data_rdata, a_av_address, a_av_writedata;
   logic [3:0]  a_av_byteenable;
   logic        b_instr_ack, b_instr_err, b_data_ack, b_data_err, b_av_read, b_av_write;
   logic [31:0] b_instr_rdata, b_data_rdata, b_av_address, b_av_writedata;
   logic [3:0]  b_av_byteenable;

   int n_tests = 0;
   int n_fail  = 0;

   // Results of the most recent data transaction on instance A
   logic [3:0]  x_be;
   logic [31:0] x_wd, x_addr, x_rdata;
   logic        x_rd, x_wr, x_stable, x_both, x_err, x_ack_twice;
   int          x_ack_cyc, x_bus_n;
   logic [31:0] exp_rdata;

   always #5 clk = ~clk;

   avalon_arbiter #(.DATA_FIRST(1), .WAIT_LIMIT(5)) dut_a (
      .clk(clk), .reset(reset),
      .instr_req(instr_req), .instr_address(instr_address),
      .instr_ack(a_instr_ack), .instr_rdata(a_instr_rdata), .instr_err(a_instr_err),
      .data_req(data_req), .data_we(data_we), .data_size(data_size),
      .data_address(data_address), .data_wdata(data_wdata),
      .data_ack(a_data_ack), .data_rdata(a_data_rdata), .data_err(a_data_err),
      .av_address(a_av_address), .av_read(a_av_read), .av_write(a_av_write),
      .av_writedata(a_av_writedata), .av_byteenable(a_av_byteenable),
      .av_waitrequest(av_waitrequest), .av_readdata(av_readdata)
   );

   avalon_arbiter #(.DATA_FIRST(0), .WAIT_LIMIT(0)) dut_b (
      .clk(clk), .reset(reset),
      .instr_req(instr_req), .instr_address(instr_address),
      .instr_ack(b_instr_ack), .instr_rdata(b_instr_rdata), .instr_err(b_instr_err),
      .data_req(data_req), .data_we(data_we), .data_size(data_size),
      .data_address(data_address), .data_wdata(data_wdata),
      .data_ack(b_data_ack), .data_rdata(b_data_rdata), .data_err(b_data_err),
      .av_address(b_av_address), .av_read(b_av_read), .av_write(b_av_write),
      .av_writedata(b_av_writedata), .av_byteenable(b_av_byteenable),
      .av_waitrequest(av_waitrequest), .av_readdata(av_readdata)
   );

   // Reference: which lanes a size/offset covers, and how data moves
   function automatic void ref_lane(input logic [1:0] sz, input logic [31:0] ad,
                                    input logic [31:0] wd, input logic [31:0] rd,
                                    output logic [3:0] be, output logic [31:0] wsh,
                                    output logic mis, output logic [31:0] rsh);
      int off;
      int nb;
      off = int'(ad[1:0]);
      nb  = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
      mis = (off % nb) != 0;
      be  = 4'b0000;
      for (int i = 0; i < nb; i++) begin
         if (off + i < 4) be[off + i] = 1'b1;
      end
      wsh = wd << (8 * off);
      rsh = rd >> (8 * off);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      instr_req      = 1'b0;
      instr_address  = 32'h0;
      data_req       = 1'b0;
      data_we        = 1'b0;
      data_size      = 2'b00;
      data_address   = 32'h0;
      data_wdata     = 32'h0;
      av_waitrequest = 1'b0;
      av_readdata    = 32'h0;
      exp_rdata      = 32'h0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Drives one data request on A, plays a slave with 'waits' stall cycles,
   // and records what the bus and requester interface showed.
   task automatic data_xact(input logic we, input logic [1:0] sz, input logic [31:0] ad,
                            input logic [31:0] wd, input int waits, input logic [31:0] rd);
      data_req     = 1'b1;
      data_we      = we;
      data_size    = sz;
      data_address = ad;
      data_wdata   = wd;
      x_ack_cyc = -1; x_bus_n = 0; x_stable = 1'b1; x_both = 1'b0; x_err = 1'b0;
      x_rd = 1'b0; x_wr = 1'b0; x_be = 4'h0; x_wd = 32'h0; x_addr = 32'h0; x_rdata = 32'h0;
      for (int c = 1; c <= 40 && x_ack_cyc < 0; c++) begin
         tick();
         if (a_av_read && a_av_write) x_both = 1'b1;
         if (a_data_ack) begin
            x_ack_cyc = c;
            x_err     = a_data_err;
            x_rdata   = a_data_rdata;
            data_req  = 1'b0;
         end else if (a_av_read || a_av_write) begin
            x_bus_n++;
            if (x_bus_n == 1) begin
               x_rd = a_av_read; x_wr = a_av_write; x_be = a_av_byteenable;
               x_wd = a_av_writedata; x_addr = a_av_address;
            end else if ({x_rd, x_wr, x_be, x_wd, x_addr} !==
                         {a_av_read, a_av_write, a_av_byteenable, a_av_writedata, a_av_address}) begin
               x_stable = 1'b0;
            end
            av_waitrequest = (x_bus_n <= waits);
            av_readdata    = (x_bus_n <= waits) ? $urandom : rd;
         end
      end
      data_req = 1'b0;
      tick();
      x_ack_twice = a_data_ack;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if ({a_instr_ack, a_instr_rdata, a_instr_err, a_data_ack, a_data_rdata, a_data_err,
           a_av_address, a_av_read, a_av_write, a_av_writedata, a_av_byteenable} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs_a: got rd=%h wr=%h be=%h addr=%h, expected all zero",
                  a_av_read, a_av_write, a_av_byteenable, a_av_address);
      end
      n_tests++;
      if ({b_instr_ack, b_instr_rdata, b_instr_err, b_data_ack, b_data_rdata, b_data_err,
           b_av_address, b_av_read, b_av_write, b_av_writedata, b_av_byteenable} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs_b: got rd=%h wr=%h be=%h, expected all zero",
                  b_av_read, b_av_write, b_av_byteenable);
      end
   endtask

   task automatic test_single_fetch();
      do_reset();
      instr_req = 1'b1; instr_address = 32'h0000_0040;
      av_waitrequest = 1'b0; av_readdata = 32'h8C01_0004;
      tick();
      n_tests++;
      if ({a_av_read, a_av_write, a_av_byteenable, a_av_address} !== {1'b1, 1'b0, 4'b1111, 32'h40}) begin
         n_fail++;
         $display("FAIL fetch_bus: got rd=%b wr=%b be=%b addr=%h, expected 1 0 1111 00000040",
                  a_av_read, a_av_write, a_av_byteenable, a_av_address);
      end
      tick();
      n_tests++;
      if ({a_instr_ack, a_instr_err, a_instr_rdata} !== {1'b1, 1'b0, 32'h8C01_0004}) begin
         n_fail++;
         $display("FAIL fetch_ack: got ack=%b err=%b rdata=%h, expected 1 0 8c010004",
                  a_instr_ack, a_instr_err, a_instr_rdata);
      end
      instr_req = 1'b0; av_readdata = 32'h0;
      tick();
      n_tests++;
      if ({a_instr_ack, a_av_read, a_instr_rdata} !== {1'b0, 1'b0, 32'h8C01_0004}) begin
         n_fail++;
         $display("FAIL fetch_after: got ack=%b rd=%b rdata=%h, expected 0 0 8c010004 held",
                  a_instr_ack, a_av_read, a_instr_rdata);
      end
   endtask

   task automatic test_priority();
      int d_ack, i_ack, f_cyc;
      logic f_wr;
      logic [31:0] f_addr, f_wd, ird;
      do_reset();
      instr_req = 1'b1; instr_address = 32'h100;
      data_req = 1'b1; data_we = 1'b1; data_size = 2'b00;
      data_address = 32'h200; data_wdata = 32'hDEAD_BEEF;
      av_waitrequest = 1'b0; av_readdata = 32'h2402_0007;
      d_ack = -1; i_ack = -1; f_cyc = -1; f_wr = 1'b0; f_addr = 32'h0; f_wd = 32'h0; ird = 32'h0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (f_cyc < 0 && (a_av_read || a_av_write)) begin
            f_cyc = c; f_wr = a_av_write; f_addr = a_av_address; f_wd = a_av_writedata;
         end
         if (a_data_ack && d_ack < 0) begin d_ack = c; data_req = 1'b0; end
         if (a_instr_ack && i_ack < 0) begin i_ack = c; instr_req = 1'b0; ird = a_instr_rdata; end
      end
      n_tests++;
      if ({f_wr, f_addr, f_wd} !== {1'b1, 32'h200, 32'hDEAD_BEEF} || f_cyc != 1) begin
         n_fail++;
         $display("FAIL prio_first_cmd: got wr=%b addr=%h wd=%h cyc=%0d, expected 1 200 deadbeef 1",
                  f_wr, f_addr, f_wd, f_cyc);
      end
      n_tests++;
      if (d_ack != 2 || i_ack != 5) begin
         n_fail++;
         $display("FAIL prio_ack_cycles: got data=%0d instr=%0d, expected 2 and 5", d_ack, i_ack);
      end
      n_tests++;
      if (ird !== 32'h2402_0007) begin
         n_fail++;
         $display("FAIL prio_fetch_data: got %h, expected 24020007", ird);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] seq_a, seq_b;
      int na, nb;
      logic prev_b, consec;
      do_reset();
      instr_req = 1'b1; instr_address = 32'h100;
      data_req = 1'b1; data_we = 1'b0; data_size = 2'b00; data_address = 32'h300;
      av_waitrequest = 1'b0; av_readdata = 32'h1357_9BDF;
      seq_a = 4'h0; seq_b = 4'h0; na = 0; nb = 0; prev_b = 1'b0; consec = 1'b0;
      for (int c = 1; c <= 40 && (na < 4 || nb < 4); c++) begin
         tick();
         if (b_data_ack || b_instr_ack) begin
            if (nb < 4) seq_b[nb] = b_data_ack;
            nb++;
            if (prev_b || (b_data_ack && b_instr_ack)) consec = 1'b1;
         end
         prev_b = b_data_ack || b_instr_ack;
         if (a_data_ack || a_instr_ack) begin
            if (na < 4) seq_a[na] = a_data_ack;
            na++;
         end
      end
      instr_req = 1'b0; data_req = 1'b0;
      n_tests++;
      if (nb < 4 || seq_b !== 4'b0101) begin
         n_fail++;
         $display("FAIL rr_order: got acks=%0d seq(bit0 first,1=data)=%b, expected 4 and 0101", nb, seq_b);
      end
      n_tests++;
      if (na < 4 || seq_a !== 4'b1111) begin
         n_fail++;
         $display("FAIL data_first_order: got acks=%0d seq=%b, expected 4 and 1111", na, seq_a);
      end
      n_tests++;
      if (consec !== 1'b0) begin
         n_fail++;
         $display("FAIL rr_ack_spacing: got back-to-back acks, expected none");
      end
   endtask

   task automatic test_lanes();
      do_reset();
      data_xact(1'b1, 2'b10, 32'h203, 32'h0000_00AB, 0, 32'h0);
      n_tests++;
      if ({x_wr, x_rd, x_be, x_wd, x_addr} !== {1'b1, 1'b0, 4'b1000, 32'hAB00_0000, 32'h200} || x_ack_cyc != 2) begin
         n_fail++;
         $display("FAIL store_byte: got wr=%b be=%b wd=%h addr=%h ack=%0d, expected 1 1000 ab000000 200 2",
                  x_wr, x_be, x_wd, x_addr, x_ack_cyc);
      end
      data_xact(1'b1, 2'b01, 32'h202, 32'h0000_BEEF, 0, 32'h0);
      n_tests++;
      if ({x_wr, x_be, x_wd, x_addr} !== {1'b1, 4'b1100, 32'hBEEF_0000, 32'h200}) begin
         n_fail++;
         $display("FAIL store_half: got wr=%b be=%b wd=%h addr=%h, expected 1 1100 beef0000 200",
                  x_wr, x_be, x_wd, x_addr);
      end
      data_xact(1'b0, 2'b10, 32'h201, 32'h0, 0, 32'h1122_3344);
      n_tests++;
      if ({x_rd, x_be, x_rdata, x_err} !== {1'b1, 4'b0010, 32'h0011_2233, 1'b0}) begin
         n_fail++;
         $display("FAIL load_byte: got rd=%b be=%b rdata=%h err=%b, expected 1 0010 00112233 0",
                  x_rd, x_be, x_rdata, x_err);
      end
      exp_rdata = 32'h0011_2233;
   endtask

   task automatic test_misaligned();
      do_reset();
      data_xact(1'b0, 2'b00, 32'h201, 32'h0, 0, 32'hFFFF_FFFF);
      n_tests++;
      if (x_ack_cyc != 1 || x_err !== 1'b1 || x_bus_n != 0 || x_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL misalign_word: got ack=%0d err=%b buscyc=%0d rdata=%h, expected 1 1 0 0",
                  x_ack_cyc, x_err, x_bus_n, x_rdata);
      end
      data_xact(1'b1, 2'b01, 32'h203, 32'h1234, 0, 32'h0);
      n_tests++;
      if (x_ack_cyc != 1 || x_err !== 1'b1 || x_bus_n != 0) begin
         n_fail++;
         $display("FAIL misalign_half: got ack=%0d err=%b buscyc=%0d, expected 1 1 0",
                  x_ack_cyc, x_err, x_bus_n);
      end
   endtask

   task automatic test_wait_and_timeout();
      do_reset();
      data_xact(1'b0, 2'b00, 32'h100, 32'h0, 3, 32'hCAFE_F00D);
      n_tests++;
      if (x_bus_n != 4 || x_stable !== 1'b1 || x_ack_cyc != 5 || x_rdata !== 32'hCAFE_F00D || x_err !== 1'b0) begin
         n_fail++;
         $display("FAIL wait3: got buscyc=%0d stable=%b ack=%0d rdata=%h err=%b, expected 4 1 5 cafef00d 0",
                  x_bus_n, x_stable, x_ack_cyc, x_rdata, x_err);
      end
      exp_rdata = 32'hCAFE_F00D;
      data_xact(1'b0, 2'b00, 32'h104, 32'h0, 100, 32'h0);
      n_tests++;
      if (x_bus_n != 5 || x_ack_cyc != 6 || x_err !== 1'b1 || x_rdata !== exp_rdata) begin
         n_fail++;
         $display("FAIL timeout_a: got buscyc=%0d ack=%0d err=%b rdata=%h, expected 5 6 1 %h",
                  x_bus_n, x_ack_cyc, x_err, x_rdata, exp_rdata);
      end
      // Instance B has no limit and must still be stalled on the same read
      n_tests++;
      if ({b_av_read, b_data_ack} !== 2'b10) begin
         n_fail++;
         $display("FAIL nolimit_stall_b: got rd=%b ack=%b, expected 1 0", b_av_read, b_data_ack);
      end
      av_waitrequest = 1'b0; av_readdata = 32'h0BAD_C0DE;
      tick();
      n_tests++;
      if ({b_data_ack, b_data_err, b_data_rdata} !== {1'b1, 1'b0, 32'h0BAD_C0DE}) begin
         n_fail++;
         $display("FAIL nolimit_done_b: got ack=%b err=%b rdata=%h, expected 1 0 0badc0de",
                  b_data_ack, b_data_err, b_data_rdata);
      end
   endtask

   task automatic test_reset_mid_bus();
      int acks;
      do_reset();
      data_req = 1'b1; data_we = 1'b1; data_size = 2'b00;
      data_address = 32'h200; data_wdata = 32'h55AA_55AA; av_waitrequest = 1'b1;
      tick();
      tick();
      n_tests++;
      if (a_av_write !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_pre: got wr=%b, expected 1", a_av_write);
      end
      reset = 1'b1;
      tick();
      n_tests++;
      if ({a_instr_ack, a_instr_rdata, a_instr_err, a_data_ack, a_data_rdata, a_data_err,
           a_av_address, a_av_read, a_av_write, a_av_writedata, a_av_byteenable} !== '0) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: got wr=%b be=%b addr=%h wd=%h, expected all zero",
                  a_av_write, a_av_byteenable, a_av_address, a_av_writedata);
      end
      reset = 1'b0; data_req = 1'b0; av_waitrequest = 1'b0;
      acks = 0;
      repeat (5) begin
         tick();
         if (a_data_ack || a_av_write) acks++;
      end
      n_tests++;
      if (acks != 0) begin
         n_fail++;
         $display("FAIL rst_mid_no_ack: got %0d ack/write cycles, expected 0", acks);
      end
   endtask

   task automatic test_random();
      logic        we, mis;
      logic [1:0]  sz;
      logic [31:0] ad, wd, rd, m_wd, m_rd;
      logic [3:0]  m_be;
      int          w;
      do_reset();
      for (int n = 0; n < 40; n++) begin
         we = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         ad = $urandom;
         if ($urandom_range(0, 2) != 0) ad[1:0] = 2'b00;
         wd = $urandom;
         rd = $urandom;
         w  = $urandom_range(0, 3);
         ref_lane(sz, ad, wd, rd, m_be, m_wd, mis, m_rd);
         data_xact(we, sz, ad, wd, w, rd);
         n_tests++;
         if (mis) begin
            if (x_ack_cyc != 1 || x_err !== 1'b1 || x_bus_n != 0) begin
               n_fail++;
               $display("FAIL rand_misalign[%0d]: got ack=%0d err=%b buscyc=%0d, expected 1 1 0 (sz=%0d ad=%h)",
                        n, x_ack_cyc, x_err, x_bus_n, sz, ad);
            end
         end else begin
            if (!we) exp_rdata = m_rd;
            if ({x_addr, x_be, x_rd, x_wr} !== {ad & 32'hFFFF_FFFC, m_be, ~we, we} ||
                (we && x_wd !== m_wd) || x_stable !== 1'b1 || x_both !== 1'b0 ||
                x_ack_cyc != w + 2 || x_bus_n != w + 1 || x_err !== 1'b0) begin
               n_fail++;
               $display("FAIL rand_xact[%0d]: got addr=%h be=%b rd=%b wr=%b wd=%h ack=%0d bus=%0d err=%b, expected %h %b %b %b %h %0d %0d 0",
                        n, x_addr, x_be, x_rd, x_wr, x_wd, x_ack_cyc, x_bus_n, x_err,
                        ad & 32'hFFFF_FFFC, m_be, ~we, we, m_wd, w + 2, w + 1);
            end
         end
         n_tests++;
         if (x_rdata !== exp_rdata || x_ack_twice !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_rdata[%0d]: got rdata=%h ack_next=%b, expected %h 0",
                     n, x_rdata, x_ack_twice, exp_rdata);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_priority();
      test_round_robin();
      test_lanes();
      test_misaligned();
      test_wait_and_timeout();
      test_reset_mid_bus();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_avalon_arbiter
`default_nettype wire
